// File: rtl/cpu_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cpu_mem_bus_arbiter
// Description : Round-robin arbiter sharing one memory bus between
//               NUM_PORTS cache requesters (port 0 = I-cache, port 1 =
//               commit-stage D-cache). One outstanding transaction at a
//               time: the winner's request is latched, driven to memory
//               until accepted, and the memory response is routed back
//               combinationally to the owning port.
//               Optional watchdog in WAIT: define CPU_MEM_ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================

`ifndef PHYSICAL_ADDR_WIDTH
`define PHYSICAL_ADDR_WIDTH 32
`endif

module cpu_mem_bus_arbiter #(
  parameter int NUM_PORTS      = 2,
  parameter int ADDR_WIDTH     = `PHYSICAL_ADDR_WIDTH,
  parameter int LINE_WIDTH     = 128,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                            clock,
  input  logic                            reset,
  // requester side
  input  logic [NUM_PORTS-1:0]            req_valid,
  input  logic [NUM_PORTS-1:0]            req_write,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_PORTS*LINE_WIDTH-1:0] req_data,
  output logic [NUM_PORTS-1:0]            req_ready,
  output logic [NUM_PORTS-1:0]            resp_valid,
  output logic [LINE_WIDTH-1:0]           resp_data,
  output logic                            resp_error,
  // memory side
  input  logic                            mem_bus_available,
  output logic                            mem_req_valid,
  output logic                            mem_req_write,
  output logic [ADDR_WIDTH-1:0]           mem_req_addr,
  output logic [LINE_WIDTH-1:0]           mem_req_data,
  input  logic                            mem_resp_valid,
  input  logic [LINE_WIDTH-1:0]           mem_resp_data,
  // status
  output logic                            busy,
  output logic [$clog2(NUM_PORTS)-1:0]    owner
);

  localparam int c_PTR_W = $clog2(NUM_PORTS);

  localparam logic [1:0] c_ST_IDLE  = 2'd0;
  localparam logic [1:0] c_ST_ISSUE = 2'd1;
  localparam logic [1:0] c_ST_WAIT  = 2'd2;

  logic [1:0]            r_state;
  logic [1:0]            w_state_nxt;
  logic [c_PTR_W-1:0]    r_rr_ptr;
  logic [c_PTR_W-1:0]    r_owner;
  logic                  r_write;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [LINE_WIDTH-1:0] r_data;

  logic                  w_found;
  logic [c_PTR_W-1:0]    w_winner;
  logic [c_PTR_W-1:0]    w_rr_nxt;
  logic                  w_grant;
  logic                  w_sel_write;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [LINE_WIDTH-1:0] w_sel_data;
  logic                  w_resp_hit;
  logic                  w_resp_fire;
  logic                  w_timeout;

  // --------------------------------------------------------------------------
  // Optional watchdog: counts WAIT cycles without a memory response.
  // The counter sits at zero outside WAIT, so it is clear on WAIT entry.
  // --------------------------------------------------------------------------
`ifdef CPU_MEM_ARB_TIMEOUT_EN
  localparam int c_TMO_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [c_TMO_W-1:0] r_tmo_cnt;

  assign w_timeout = (r_state == c_ST_WAIT) && !mem_resp_valid &&
                     (r_tmo_cnt == c_TMO_W'(TIMEOUT_CYCLES));

  // Watchdog counter: runs only while waiting on memory
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_tmo_cnt <= '0;
    end else if (r_state != c_ST_WAIT) begin
      r_tmo_cnt <= '0;
    end else if (!mem_resp_valid && !w_timeout) begin
      r_tmo_cnt <= r_tmo_cnt + c_TMO_W'(1);
    end
  end
`else
  // Without the watchdog WAIT is left only by a real memory response.
  logic w_unused_cfg;
  assign w_unused_cfg = (TIMEOUT_CYCLES > 0);
  assign w_timeout    = 1'b0;
`endif

  // Round-robin search: first requester at or above the pointer, else the
  // lowest requester below it (wrap-around).
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!w_found && req_valid[i] && (i >= int'(r_rr_ptr))) begin
        w_found  = 1'b1;
        w_winner = c_PTR_W'(i);
      end
    end
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!w_found && req_valid[i]) begin
        w_found  = 1'b1;
        w_winner = c_PTR_W'(i);
      end
    end
  end

  assign w_grant  = (r_state == c_ST_IDLE) && w_found;
  assign w_rr_nxt = (w_winner == c_PTR_W'(NUM_PORTS - 1)) ? '0 : w_winner + c_PTR_W'(1);

  // Select the winning port's request fields from the flat buses
  always_comb begin
    w_sel_write = 1'b0;
    w_sel_addr  = '0;
    w_sel_data  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (w_winner == c_PTR_W'(i)) begin
        w_sel_write = req_write[i];
        w_sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        w_sel_data  = req_data[i*LINE_WIDTH +: LINE_WIDTH];
      end
    end
  end

  assign w_resp_hit  = (r_state == c_ST_WAIT) && mem_resp_valid;
  assign w_resp_fire = w_resp_hit || w_timeout;

  // Next-state logic for IDLE -> ISSUE -> WAIT -> IDLE
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE:  if (w_found)           w_state_nxt = c_ST_ISSUE;
      c_ST_ISSUE: if (mem_bus_available) w_state_nxt = c_ST_WAIT;
      c_ST_WAIT:  if (w_resp_fire)       w_state_nxt = c_ST_IDLE;
      default:                           w_state_nxt = c_ST_IDLE;
    endcase
  end

  // State register; reset aborts any transaction without a response
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Latch the winner's request and advance the round-robin pointer on grant
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rr_ptr <= '0;
      r_owner  <= '0;
      r_write  <= 1'b0;
      r_addr   <= '0;
      r_data   <= '0;
    end else if (w_grant) begin
      r_rr_ptr <= w_rr_nxt;
      r_owner  <= w_winner;
      r_write  <= w_sel_write;
      r_addr   <= w_sel_addr;
      r_data   <= w_sel_data;
    end
  end

  // One-hot grant and response steering
  always_comb begin
    req_ready  = '0;
    resp_valid = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (w_grant && (w_winner == c_PTR_W'(i))) begin
        req_ready[i] = 1'b1;
      end
      if (w_resp_fire && (r_owner == c_PTR_W'(i))) begin
        resp_valid[i] = 1'b1;
      end
    end
  end

  // Read data passes straight through on a real response, zero otherwise
  assign resp_data  = w_resp_hit ? mem_resp_data : '0;
  assign resp_error = w_timeout;

  // Memory request is presented only in ISSUE, held from the latched fields
  assign mem_req_valid = (r_state == c_ST_ISSUE);
  assign mem_req_write = mem_req_valid && r_write;
  assign mem_req_addr  = mem_req_valid ? r_addr : '0;
  assign mem_req_data  = mem_req_valid ? r_data : '0;

  assign busy  = (r_state != c_ST_IDLE);
  assign owner = r_owner;

endmodule

`default_nettype wire

// File: tb/tb_cpu_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_mem_bus_arbiter
// Description : Scoreboard bench for cpu_mem_bus_arbiter. A transaction-level
//               model of requesters and memory predicts grants, memory
//               issues and responses into queues; a monitor pops and compares.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps

module tb_cpu_mem_bus_arbiter;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int LW = 128;
  localparam int OW = $clog2(N);
`ifdef CPU_MEM_ARB_TIMEOUT_EN
  localparam int TO = 10;
`else
  localparam int TO = 255;
`endif

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_write = '0;
  logic [N*AW-1:0] req_addr  = '0;
  logic [N*LW-1:0] req_data  = '0;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    resp_valid;
  logic [LW-1:0]   resp_data;
  logic            resp_error;
  logic            mem_bus_available = 1'b0;
  logic            mem_req_valid;
  logic            mem_req_write;
  logic [AW-1:0]   mem_req_addr;
  logic [LW-1:0]   mem_req_data;
  logic            mem_resp_valid = 1'b0;
  logic [LW-1:0]   mem_resp_data  = '0;
  logic            busy;
  logic [OW-1:0]   owner;

  cpu_mem_bus_arbiter #(
    .NUM_PORTS(N), .ADDR_WIDTH(AW), .LINE_WIDTH(LW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_data(req_data), .req_ready(req_ready), .resp_valid(resp_valid),
    .resp_data(resp_data), .resp_error(resp_error),
    .mem_bus_available(mem_bus_available), .mem_req_valid(mem_req_valid),
    .mem_req_write(mem_req_write), .mem_req_addr(mem_req_addr),
    .mem_req_data(mem_req_data), .mem_resp_valid(mem_resp_valid),
    .mem_resp_data(mem_resp_data), .busy(busy), .owner(owner)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct { int cyc; logic [N-1:0] vec; } grant_t;
  typedef struct { int cyc; logic wr; logic [AW-1:0] addr; logic [LW-1:0] data; } issue_t;
  typedef struct { int cyc; logic [N-1:0] vec; logic [LW-1:0] data; logic err; } resp_t;
  typedef struct { int cyc; logic busy; logic [OW-1:0] owner; } stat_t;

  grant_t grant_q[$];
  issue_t issue_q[$];
  resp_t  resp_q[$];
  stat_t  stat_q[$];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  // ---------------- reference model state ----------------
  int phase   = 0;   // 0 idle, 1 issuing to memory, 2 waiting on memory
  int rr      = 0;   // first port to consider at next arbitration
  int own     = 0;
  int wait_n  = 0;   // WAIT cycles already elapsed
  int resp_at = 0;   // WAIT cycle index on which memory answers
  logic          t_wr;
  logic [AW-1:0] t_addr;
  logic [LW-1:0] t_data;

  logic          p_valid[N];
  logic          p_write[N];
  logic [AW-1:0] p_addr[N];
  logic [LW-1:0] p_data[N];

  // stimulus knobs
  int k_req = 0, k_withdraw = 0, k_bus = 100, k_dmin = 0, k_dmax = 0, k_stray = 0, k_hold = 0;

  function automatic logic [LW-1:0] rnd_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic force_req(input int p, input logic w, input logic [AW-1:0] a, input logic [LW-1:0] d);
    p_valid[p] = 1'b1; p_write[p] = w; p_addr[p] = a; p_data[p] = d;
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < N; i++) begin
      req_valid[i]            = p_valid[i];
      req_write[i]            = p_write[i];
      req_addr[i*AW +: AW]    = p_addr[i];
      req_data[i*LW +: LW]    = p_data[i];
    end
  endtask

  task automatic push_stat(input logic b, input int o);
    stat_t s;
    s.cyc = cyc; s.busy = b; s.owner = OW'(o);
    stat_q.push_back(s);
  endtask

  // One reset cycle: model returns to power-on state, outputs must be zero.
  task automatic reset_step();
    reset = 1'b1;
    phase = 0; rr = 0; own = 0;
    for (int i = 0; i < N; i++) p_valid[i] = 1'b0;
    drive_reqs();
    mem_bus_available = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
    push_stat(1'b0, 0);
    #1;
    chk("reset_ctrl", LW'({req_ready, resp_valid, resp_error, mem_req_valid,
                           mem_req_write, busy, owner, mem_req_addr}), '0);
    chk("reset_data", mem_req_data | resp_data, '0);
  endtask

  // One normal cycle of requesters + memory, predicting DUT behaviour.
  task automatic step();
    grant_t g; issue_t is; resp_t r;
    int win;
    reset = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (p_valid[i] && ($urandom_range(99) < k_withdraw)) p_valid[i] = 1'b0;
      else if (!p_valid[i] && ($urandom_range(99) < k_req))
        force_req(i, 1'($urandom), $urandom, rnd_line());
    end
    drive_reqs();
    mem_bus_available = 1'($urandom);
    mem_resp_valid    = 1'b0;
    mem_resp_data     = rnd_line();
    push_stat(phase != 0, own);
    if (phase != 2 && ($urandom_range(99) < k_stray)) mem_resp_valid = 1'b1;
    case (phase)
      0: begin
        win = -1;
        for (int k = 0; k < N; k++)
          if (win < 0 && p_valid[(rr + k) % N]) win = (rr + k) % N;
        if (win >= 0) begin
          g.cyc = cyc; g.vec = '0; g.vec[win] = 1'b1;
          grant_q.push_back(g);
          t_wr = p_write[win]; t_addr = p_addr[win]; t_data = p_data[win];
          own = win; rr = (win + 1) % N; phase = 1;
          p_valid[win] = 1'b0;
        end
      end
      1: begin
        is.cyc = cyc; is.wr = t_wr; is.addr = t_addr; is.data = t_data;
        issue_q.push_back(is);
        if (k_hold > 0) begin
          mem_bus_available = 1'b0;
          k_hold--;
        end else if ($urandom_range(99) < k_bus) begin
          mem_bus_available = 1'b1;
          phase = 2; wait_n = 0;
          resp_at = $urandom_range(k_dmax, k_dmin);
        end else begin
          mem_bus_available = 1'b0;
        end
      end
      default: begin
        r.cyc = cyc; r.vec = '0; r.vec[own] = 1'b1; r.err = 1'b0;
        if (wait_n == resp_at) begin
          mem_resp_valid = 1'b1;
          r.data = mem_resp_data;
          resp_q.push_back(r);
          phase = 0;
        end
`ifdef CPU_MEM_ARB_TIMEOUT_EN
        else if (wait_n == TO) begin
          r.data = '0; r.err = 1'b1;
          resp_q.push_back(r);
          phase = 0;
        end
`endif
        else begin
          wait_n++;
        end
      end
    endcase
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(posedge clock); #1;
      step();
    end
  endtask

  // ---------------- monitor ----------------
  initial begin
    stat_t s; issue_t is; resp_t r;
    logic [N-1:0] gv;
    forever begin
      @(negedge clock);
      if (stat_q.size() == 0) begin
        total++; bad++;
        $display("FAIL status_underflow cyc=%0d got=empty want=entry", cyc);
      end else begin
        s = stat_q.pop_front();
        chk("busy", LW'(busy), LW'(s.busy));
        chk("owner", LW'(owner), LW'(s.owner));
      end
      gv = '0;
      if (grant_q.size() > 0 && grant_q[0].cyc == cyc) gv = grant_q.pop_front().vec;
      chk("req_ready", LW'(req_ready), LW'(gv));
      if (issue_q.size() > 0 && issue_q[0].cyc == cyc) begin
        is = issue_q.pop_front();
        chk("mem_req_valid", LW'(mem_req_valid), LW'(1'b1));
        chk("mem_req_write", LW'(mem_req_write), LW'(is.wr));
        chk("mem_req_addr", LW'(mem_req_addr), LW'(is.addr));
        chk("mem_req_data", mem_req_data, is.data);
      end else begin
        chk("mem_req_valid_idle", LW'(mem_req_valid), '0);
      end
      if (resp_q.size() > 0 && resp_q[0].cyc == cyc) begin
        r = resp_q.pop_front();
        chk("resp_valid", LW'(resp_valid), LW'(r.vec));
        chk("resp_data", resp_data, r.data);
        chk("resp_error", LW'(resp_error), LW'(r.err));
      end else begin
        chk("resp_quiet", LW'({resp_valid, resp_error}), '0);
        chk("resp_data_quiet", resp_data, '0);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < N; i++) begin
      p_valid[i] = 1'b0; p_write[i] = 1'b0; p_addr[i] = '0; p_data[i] = '0;
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      reset_step();
    end

    // single read on port 0
    k_req = 0; k_bus = 100; k_dmin = 2; k_dmax = 2;
    force_req(0, 1'b0, 32'h1A0, rnd_line());
    run(8);

    // contention: everybody requests all the time
    k_req = 100; k_dmin = 0; k_dmax = 0;
    run(24);
    k_req = 0;
    run(6);

    // backpressure: memory refuses five ISSUE cycles
    k_hold = 5;
    force_req(0, 1'b1, $urandom, rnd_line());
    run(12);

    // write ack on port 1, with stray memory responses outside WAIT
    k_stray = 100; k_dmin = 1; k_dmax = 1;
    force_req(1, 1'b1, 32'h040, {32{4'h5}});
    run(10);

    // randomized traffic
    k_req = 30; k_withdraw = 5; k_bus = 60; k_dmin = 0; k_dmax = 6; k_stray = 20;
    run(1500);
    k_req = 0; k_withdraw = 0; k_stray = 0; k_bus = 100;
    run(20);

    // reset while port 1 waits on memory
    k_dmin = 100000; k_dmax = 100000;
    force_req(1, 1'b0, $urandom, rnd_line());
    for (int i = 0; i < 40 && !(phase == 2 && wait_n >= 2); i++) begin
      @(posedge clock); #1;
      step();
    end
    for (int i = 0; i < 2; i++) begin
      @(posedge clock); #1;
      reset_step();
    end
    k_dmin = 2; k_dmax = 2;
    force_req(0, 1'b0, 32'h1A0, rnd_line());
    run(10);

`ifdef CPU_MEM_ARB_TIMEOUT_EN
    // memory never answers: watchdog must complete with an error
    k_dmin = 100000; k_dmax = 100000;
    force_req(1, 1'b0, $urandom, rnd_line());
    run(TO + 10);
    k_dmin = 0; k_dmax = 3;
    force_req(0, 1'b0, $urandom, rnd_line());
    run(10);
`endif

    run(10);
    @(negedge clock); #1;
    chk("grant_q_left", LW'(grant_q.size()), '0);
    chk("issue_q_left", LW'(issue_q.size()), '0);
    chk("resp_q_left", LW'(resp_q.size()), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
